// File: rtl/controlador_modo.sv
// Mode controller: turns the raw MODO/AJUSTE buttons into the one-hot operating mode
// and the field being edited while in an adjust mode.
module controlador_modo #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_modo,
    input  logic       btn_ajuste,
    output logic       modo_relogio,
    output logic       modo_cronometro,
    output logic       modo_timer,
    output logic       modo_ajuste_relogio,
    output logic       modo_ajuste_timer,
    output logic [1:0] campo_sel,
    output logic       troca_modo
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        RELOGIO,
        CRONOMETRO,
        TIMER,
        AJ_RELOGIO,
        AJ_TIMER
    } estado_t;

    // Index 0 = MODO, index 1 = AJUSTE
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      level_q, level_d;
    logic [1:0]      press_q, press_d;
    logic [1:0]      armed_q, armed_d;
    logic [1:0]      primed_q, primed_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    estado_t          state_q, state_d;
    logic [1:0]       campo_q, campo_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [4:0]       modo_q, modo_d;
    logic             troca_q, troca_d;
    logic             press_modo, press_aj;

    assign btn_raw = {btn_ajuste, btn_modo};

    // A button only becomes armed once it has been seen released after reset, so a
    // button held through reset cannot produce a press until it is pressed again.
    always_comb begin
        primed_d = {primed_q[0], 1'b1};
        level_d  = level_q;
        press_d  = '0;
        armed_d  = armed_q | ({2{primed_q[1]}} & ~sync2_q);
        for (int b = 0; b < 2; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    level_d[b] = ~level_q[b];
                    press_d[b] = ~level_q[b] & armed_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            press_q  <= '0;
            armed_q  <= '0;
            primed_q <= '0;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            press_q  <= press_d;
            armed_q  <= armed_d;
            primed_q <= primed_d;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
        end
    end

    assign press_modo = press_q[0];
    assign press_aj   = press_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RELOGIO;
            campo_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            campo_q <= campo_d;
            tmo_q   <= tmo_d;
        end
    end

    // AJUSTE has priority: a MODO press in the same cycle is dropped.
    always_comb begin
        state_d = state_q;
        campo_d = campo_q;
        tmo_d   = '0;
        unique case (state_q)
            RELOGIO: begin
                if (press_aj) begin
                    state_d = AJ_RELOGIO;
                    campo_d = '0;
                end else if (press_modo) begin
                    state_d = CRONOMETRO;
                end
            end
            CRONOMETRO: begin
                if (!press_aj && press_modo) state_d = TIMER;
            end
            TIMER: begin
                if (press_aj) begin
                    state_d = AJ_TIMER;
                    campo_d = '0;
                end else if (press_modo) begin
                    state_d = RELOGIO;
                end
            end
            AJ_RELOGIO, AJ_TIMER: begin
                if (press_aj || tmo_q == TMO_LAST) begin
                    state_d = (state_q == AJ_RELOGIO) ? RELOGIO : TIMER;
                    campo_d = '0;
                end else if (press_modo) begin
                    campo_d = (campo_q == 2'd2) ? 2'd0 : campo_q + 2'd1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = RELOGIO;
                campo_d = '0;
            end
        endcase
    end

    always_comb begin
        modo_d  = 5'b10000;
        troca_d = (state_d != state_q);
        unique case (state_d)
            RELOGIO:    modo_d = 5'b10000;
            CRONOMETRO: modo_d = 5'b01000;
            TIMER:      modo_d = 5'b00100;
            AJ_RELOGIO: modo_d = 5'b00010;
            AJ_TIMER:   modo_d = 5'b00001;
            default:    modo_d = 5'b10000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modo_q  <= 5'b10000;
            troca_q <= 1'b0;
        end else begin
            modo_q  <= modo_d;
            troca_q <= troca_d;
        end
    end

    assign {modo_relogio, modo_cronometro, modo_timer,
            modo_ajuste_relogio, modo_ajuste_timer} = modo_q;
    assign campo_sel  = campo_q;
    assign troca_modo = troca_q;

endmodule
